lsu_mem_ctrl: RTL and testbench



---
 rtl/lsu_mem_ctrl.sv | 170 +++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store access controller in front of a word-wide data RAM.
//
// Takes byte/half/word load and store requests from the core's MEM stage, turns them into
// word-aligned RAM traffic, does read-modify-write for sub-word stores and extracts /
// extends sub-word load data from the RAM's 1-cycle registered read. Misaligned and
// illegal accesses are flagged instead of touching memory.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid_i/req_ready_o  request handshake; one request every 2 cycles
//   req_we_i                 1 = store, 0 = load
//   req_funct3_i             RV32 funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   req_addr_i               byte address
//   req_wdata_i              right-aligned store data
//   resp_valid_o             one-cycle completion pulse, accept+2
//   resp_rdata_o             extended load result (0 for stores and errors)
//   resp_err_o               misaligned/illegal access, qualified by resp_valid_o
//   ram_raddr_o/ram_rdata_i  RAM read port, data valid the cycle after the address
//   ram_we_o/ram_waddr_o/ram_wdata_o  RAM write port, full merged word
module lsu_mem_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  resp_valid_o,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_err_o,
  output logic [ADDR_WIDTH-1:0] ram_raddr_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_waddr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o
);

  typedef enum logic [1:0] {StIdle, StLoad, StStore, StErr} state_e;

  state_e                state_q;
  logic                  we_q;
  logic [2:0]            funct3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic                  accept;
  logic                  req_err;
  logic [ADDR_WIDTH-1:0] raddr_src;
  logic [7:0]            load_byte;
  logic [15:0]           load_half;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] store_word;

  // The top address bit never reaches the RAM.
  logic unused_addr_msb;
  assign unused_addr_msb = addr_q[ADDR_WIDTH-1];

  assign req_ready_o = (state_q == StIdle);
  assign accept      = req_valid_i && req_ready_o;

  // Alignment / legality of the incoming request, evaluated at accept.
  always_comb begin
    req_err = 1'b0;
    if (req_we_i) begin
      case (req_funct3_i)
        3'd0:    req_err = 1'b0;
        3'd1:    req_err = req_addr_i[0];
        3'd2:    req_err = |req_addr_i[1:0];
        default: req_err = 1'b1;
      endcase
    end else begin
      case (req_funct3_i)
        3'd0, 3'd4: req_err = 1'b0;
        3'd1, 3'd5: req_err = req_addr_i[0];
        3'd2:       req_err = |req_addr_i[1:0];
        default:    req_err = 1'b1;
      endcase
    end
  end

  // In IDLE the read is launched straight from the request so the data arrives in the
  // LOAD/STORE cycle; afterwards the captured address keeps the port stable.
  assign raddr_src   = (state_q == StIdle) ? req_addr_i : addr_q;
  assign ram_raddr_o = {1'b0, raddr_src[ADDR_WIDTH-2:2], 2'b00};

  // Load extraction and extension.
  assign load_byte = ram_rdata_i[{addr_q[1:0], 3'b000} +: 8];
  assign load_half = ram_rdata_i[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    load_data = ram_rdata_i;
    case (funct3_q)
      3'd0:    load_data = {{(DATA_WIDTH-8){load_byte[7]}}, load_byte};
      3'd1:    load_data = {{(DATA_WIDTH-16){load_half[15]}}, load_half};
      3'd4:    load_data = {{(DATA_WIDTH-8){1'b0}}, load_byte};
      3'd5:    load_data = {{(DATA_WIDTH-16){1'b0}}, load_half};
      default: load_data = ram_rdata_i;
    endcase
  end

  // Read-modify-write merge: old word from the RAM with the stored lane replaced.
  always_comb begin
    store_word = ram_rdata_i;
    case (funct3_q[1:0])
      2'd0:    store_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'd1:    store_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: store_word = wdata_q;
    endcase
  end

  assign ram_we_o    = (state_q == StStore);
  assign ram_waddr_o = {1'b0, addr_q[ADDR_WIDTH-2:2], 2'b00};
  assign ram_wdata_o = store_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      we_q         <= 1'b0;
      funct3_q     <= 3'd0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_o <= 1'b0;
      resp_rdata_o <= '0;
      resp_err_o   <= 1'b0;
    end else begin
      resp_valid_o <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            we_q     <= req_we_i;
            funct3_q <= req_funct3_i;
            addr_q   <= req_addr_i;
            wdata_q  <= req_wdata_i;
            if (req_err)       state_q <= StErr;
            else if (req_we_i) state_q <= StStore;
            else               state_q <= StLoad;
          end
        end
        StLoad: begin
          resp_valid_o <= 1'b1;
          resp_rdata_o <= load_data;
          resp_err_o   <= 1'b0;
          state_q      <= StIdle;
        end
        StStore: begin
          resp_valid_o <= 1'b1;
          resp_rdata_o <= '0;
          resp_err_o   <= 1'b0;
          state_q      <= StIdle;
        end
        StErr: begin
          resp_valid_o <= 1'b1;
          resp_rdata_o <= '0;
          resp_err_o   <= 1'b1;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // we_q is kept for debug visibility of the captured request.
  logic unused_we_q;
  assign unused_we_q = we_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Testbench for lsu_mem_ctrl: directed test-plan steps followed by random requests, all
// checked against a word-array reference model of memory plus the access rules.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] ram_raddr, ram_rdata, ram_waddr, ram_wdata;
  logic        ram_we;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lsu_mem_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_funct3_i (req_funct3),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .resp_valid_o (resp_valid),
    .resp_rdata_o (resp_rdata),
    .resp_err_o   (resp_err),
    .ram_raddr_o  (ram_raddr),
    .ram_rdata_i  (ram_rdata),
    .ram_we_o     (ram_we),
    .ram_waddr_o  (ram_waddr),
    .ram_wdata_o  (ram_wdata)
  );

  // RAM stub: 64 words, registered read, preloaded from the reference image.
  logic [31:0] ram  [64];
  logic [31:0] gold [64];
  logic        preload;

  always @(posedge clk) begin
    if (preload) begin
      ram <= gold;
    end else begin
      if (ram_we) ram[ram_waddr[7:2]] <= ram_wdata;
      ram_rdata <= ram[ram_raddr[7:2]];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int lo;
    lo = a % 4;
    if (we) begin
      if (f3 >= 3) return 1'b1;
      if (f3 == 1) return (lo % 2) != 0;
      if (f3 == 2) return lo != 0;
      return 1'b0;
    end
    if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
    if (f3 == 1 || f3 == 5) return (lo % 2) != 0;
    if (f3 == 2) return lo != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] w,
                                           input logic [31:0] a);
    logic [31:0] b, h;
    b = (w >> (8 * (a % 4))) & 32'hFF;
    h = (w >> (16 * ((a % 4) / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] ref_store(input logic [2:0] f3, input logic [31:0] w,
                                            input logic [31:0] a, input logic [31:0] d);
    logic [31:0] mask;
    int sh;
    if (f3 == 2) return d;
    if (f3 == 1) begin
      sh = 16 * ((a % 4) / 2);
      mask = 32'hFFFF << sh;
      return (w & ~mask) | ((d & 32'hFFFF) << sh);
    end
    sh = 8 * (a % 4);
    mask = 32'hFF << sh;
    return (w & ~mask) | ((d & 32'hFF) << sh);
  endfunction

  // Issue one request starting at a negedge while idle; returns at the negedge where the
  // response pulse is visible, so the next call is accepted back-to-back.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input string tag, output logic [31:0] got);
    logic        err;
    logic [31:0] exp_rd, new_w, al;
    int          idx;
    err    = ref_err(we, f3, a);
    idx    = int'(a[7:2]);
    al     = {1'b0, a[30:2], 2'b00};
    exp_rd = 32'h0;
    new_w  = gold[idx];
    if (!err && !we) exp_rd = ref_load(f3, gold[idx], a);
    if (!err && we)  new_w  = ref_store(f3, gold[idx], a, d);

    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
    #1;
    check({tag, ".ready_idle"}, 32'(req_ready), 32'd1);
    check({tag, ".raddr_idle"}, ram_raddr, al);
    @(posedge clk);
    #1;
    // Scramble the request bus; the DUT must work from its captured copy.
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom);
    @(negedge clk);
    check({tag, ".ready_busy"}, 32'(req_ready), 32'd0);
    check({tag, ".valid_early"}, 32'(resp_valid), 32'd0);
    check({tag, ".ram_we"}, 32'(ram_we), 32'(we && !err));
    if (we && !err) begin
      check({tag, ".waddr"}, ram_waddr, al);
      check({tag, ".wdata"}, ram_wdata, new_w);
    end
    gold[idx] = new_w;
    @(negedge clk);
    check({tag, ".valid"}, 32'(resp_valid), 32'd1);
    check({tag, ".err"}, 32'(resp_err), 32'(err));
    check({tag, ".rdata"}, resp_rdata, exp_rd);
    got = resp_rdata;
  endtask

  logic [31:0] got;

  initial begin
    rst = 1'b1; preload = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < 64; i++) gold[i] = $urandom;
    gold[8] = 32'h8070_F0A5;
    repeat (2) @(negedge clk);
    check("rst.valid", 32'(resp_valid), 32'd0);
    check("rst.rdata", resp_rdata, 32'd0);
    check("rst.err", 32'(resp_err), 32'd0);
    check("rst.we", 32'(ram_we), 32'd0);
    preload = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // Reset during the STORE cycle of SB 0x10.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h10; req_wdata = 32'h5A;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rstmid.we_before", 32'(ram_we), 32'd1);
    rst = 1'b1;
    #1;
    check("rstmid.we_drop", 32'(ram_we), 32'd0);
    check("rstmid.valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstmid.ready", 32'(req_ready), 32'd1);
    check("rstmid.valid_after", 32'(resp_valid), 32'd0);
    do_req(1'b0, 3'd2, 32'h10, 32'h0, "rstmid.lw", got);

    // Sub-word loads from 0x20.
    do_req(1'b0, 3'd0, 32'h20, 32'h0, "lb20", got);  check("lb20.const", got, 32'hFFFF_FFA5);
    do_req(1'b0, 3'd4, 32'h21, 32'h0, "lbu21", got); check("lbu21.const", got, 32'h0000_00F0);
    do_req(1'b0, 3'd1, 32'h22, 32'h0, "lh22", got);  check("lh22.const", got, 32'hFFFF_8070);
    do_req(1'b0, 3'd5, 32'h22, 32'h0, "lhu22", got); check("lhu22.const", got, 32'h0000_8070);
    do_req(1'b0, 3'd2, 32'h20, 32'h0, "lw20", got);  check("lw20.const", got, 32'h8070_F0A5);

    // Read-modify-write stores.
    do_req(1'b1, 3'd2, 32'h40, 32'h1122_3344, "sw40", got);
    do_req(1'b1, 3'd0, 32'h43, 32'h0000_00AB, "sb43", got);
    do_req(1'b0, 3'd2, 32'h40, 32'h0, "lw40a", got); check("lw40a.const", got, 32'hAB22_3344);
    do_req(1'b1, 3'd1, 32'h40, 32'h0000_BEEF, "sh40", got);
    do_req(1'b0, 3'd2, 32'h40, 32'h0, "lw40b", got); check("lw40b.const", got, 32'hAB22_BEEF);

    // Error cases.
    do_req(1'b0, 3'd2, 32'h41, 32'h0, "lw41.err", got);
    do_req(1'b1, 3'd1, 32'h43, 32'h1234, "sh43.err", got);
    do_req(1'b0, 3'd2, 32'h40, 32'h0, "lw40c", got); check("lw40c.const", got, 32'hAB22_BEEF);
    do_req(1'b0, 3'd3, 32'h40, 32'h0, "ld3.err", got);

    // Back-to-back store then load of the same word.
    do_req(1'b1, 3'd2, 32'h80, 32'hDEAD_BEEF, "sw80", got);
    do_req(1'b0, 3'd2, 32'h80, 32'h0, "lw80", got); check("lw80.const", got, 32'hDEAD_BEEF);

    // Address bit 31 is ignored.
    do_req(1'b0, 3'd2, 32'h8000_0020, 32'h0, "lw_msb", got);
    check("lw_msb.const", got, 32'h8070_F0A5);

    // Random traffic against the reference model.
    for (int i = 0; i < 200; i++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) a[31] = 1'b1;
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, "rand", got);
    end

    req_valid = 1'b0;
    @(negedge clk);
    check("tail.valid_pulse", 32'(resp_valid), 32'd0);
    check("tail.ready", 32'(req_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
